// File: rtl/fp2int_pkg.sv
// Shared types and constants for the FP32 -> int32 converter.
// Optional macro FP2INT_ROUND_NEAREST_EN selects round-to-nearest-even in fp2int_fsm.
package fp2int_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    ROUND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    SPEC = 2'd2
  } fp_class_t;

  localparam int FP_BIAS    = 127;
  localparam int MANT_W     = 23;
  localparam int MAX_RSHIFT = 25;

  localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN = 32'h80000000;

  // Bits moved in one SHIFT cycle: the configured step, clipped to what is left.
  function automatic logic [4:0] step_clip(input logic [4:0] rem, input logic [4:0] step);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 field decoder: sign, unbiased exponent, mantissa with
// hidden bit, operand class and NaN/Inf detection.
module fp32_unpack
  import fp2int_pkg::*;
(
  input  logic [31:0]       f,
  output logic              sign,
  output logic signed [8:0] exp_unb,
  output logic [23:0]       mant,
  output logic [1:0]        cls,
  output logic              is_nan,
  output logic              is_inf
);

  logic exp_zero;
  logic exp_ones;
  fp_class_t cls_val;

  assign exp_zero = (f[30:23] == 8'd0);
  assign exp_ones = (f[30:23] == 8'hFF);

  assign sign    = f[31];
  assign exp_unb = $signed({1'b0, f[30:23]}) - 9'(FP_BIAS);
  assign mant    = {1'b1, f[MANT_W-1:0]};
  assign is_inf  = exp_ones && (f[MANT_W-1:0] == 23'd0);
  assign is_nan  = exp_ones && (f[MANT_W-1:0] != 23'd0);

  // Denormals fall into ZERO: their magnitude is far below one LSB of the result.
  always_comb begin
    cls_val = NORM;
    if (exp_zero) begin
      cls_val = ZERO;
    end else if (exp_ones) begin
      cls_val = SPEC;
    end
  end

  assign cls = cls_val;

endmodule

// File: rtl/fp2int_fsm.sv
// Multi-cycle FP32 -> signed int32 converter with a serial barrel shifter.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp2int_fsm
  import fp2int_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_i,
  input  logic [31:0] f,
  output logic [31:0] q,
  output logic        r_o,
  output logic        busy,
  output logic        ovf
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state_reg, state_next;
  logic [31:0] f_reg, f_next;
  logic [31:0] acc_reg, acc_next;
  logic [4:0]  rem_reg, rem_next;
  logic        left_reg, left_next;
  logic        sign_reg, sign_next;
  logic        sat_reg, sat_next;
  logic        nan_reg, nan_next;
  logic        exact_min_reg, exact_min_next;
  logic [31:0] q_reg, q_next;
  logic        ovf_reg, ovf_next;
  logic        r_o_reg, r_o_next;
  logic        busy_reg, busy_next;
`ifdef FP2INT_ROUND_NEAREST_EN
  logic        guard_reg, guard_next;
  logic        sticky_reg, sticky_next;
  logic [4:0]  step_m1;
`endif

  logic              u_sign;
  logic signed [8:0] u_exp;
  logic [23:0]       u_mant;
  logic [1:0]        u_cls;
  logic              u_nan;
  logic              u_inf;

  fp32_unpack u_unpack (
    .f       (f_reg),
    .sign    (u_sign),
    .exp_unb (u_exp),
    .mant    (u_mant),
    .cls     (u_cls),
    .is_nan  (u_nan),
    .is_inf  (u_inf)
  );

  logic [4:0]        step;
  logic signed [8:0] rsh;
  logic              inc;
  logic [32:0]       mag;

  always_comb begin
    state_next     = state_reg;
    f_next         = f_reg;
    acc_next       = acc_reg;
    rem_next       = rem_reg;
    left_next      = left_reg;
    sign_next      = sign_reg;
    sat_next       = sat_reg;
    nan_next       = nan_reg;
    exact_min_next = exact_min_reg;
    q_next         = q_reg;
    ovf_next       = ovf_reg;
    r_o_next       = r_o_reg;
    busy_next      = busy_reg;
    step           = step_clip(rem_reg, STEP);
    rsh            = 9'sd23 - u_exp;
`ifdef FP2INT_ROUND_NEAREST_EN
    guard_next  = guard_reg;
    sticky_next = sticky_reg;
    step_m1     = step - 5'd1;
    inc         = guard_reg & (sticky_reg | acc_reg[0]);
`else
    inc         = 1'b0;
`endif
    mag = {1'b0, acc_reg} + {32'd0, inc};

    case (state_reg)
      IDLE: begin
        r_o_next = 1'b0;
        if (r_i) begin
          f_next     = f;
          busy_next  = 1'b1;
          state_next = LOAD;
        end
      end

      LOAD: begin
        sign_next      = u_sign;
        sat_next       = 1'b0;
        nan_next       = 1'b0;
        exact_min_next = 1'b0;
        left_next      = 1'b0;
        acc_next       = 32'd0;
        rem_next       = 5'd0;
`ifdef FP2INT_ROUND_NEAREST_EN
        guard_next  = 1'b0;
        sticky_next = 1'b0;
`endif
        if (u_cls == ZERO) begin
          acc_next = 32'd0;
        end else if (u_nan || u_inf || (u_exp >= 9'sd31)) begin
          // -2^31 exactly is representable; everything else here saturates.
          sat_next       = 1'b1;
          nan_next       = u_nan;
          exact_min_next = u_sign && (u_exp == 9'sd31) && (u_mant[MANT_W-1:0] == 23'd0);
        end else if (u_exp >= 9'sd23) begin
          left_next = 1'b1;
          acc_next  = {8'd0, u_mant};
          rem_next  = 5'(u_exp - 9'sd23);
        end else begin
          acc_next = {8'd0, u_mant};
          rem_next = (rsh > 9'(MAX_RSHIFT)) ? 5'(MAX_RSHIFT) : 5'(rsh);
        end
        state_next = (rem_next == 5'd0) ? ROUND : SHIFT;
      end

      SHIFT: begin
        acc_next = left_reg ? (acc_reg << step) : (acc_reg >> step);
`ifdef FP2INT_ROUND_NEAREST_EN
        if (!left_reg) begin
          // The previous guard is no longer the last bit out, so it joins sticky.
          guard_next  = acc_reg[step_m1];
          sticky_next = sticky_reg | guard_reg |
                        (|(acc_reg & ~(32'hFFFFFFFF << step_m1)));
        end
`endif
        rem_next = rem_reg - step;
        if (rem_next == 5'd0) begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        r_o_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
        if (sat_reg) begin
          q_next   = (nan_reg || !sign_reg) ? INT_MAX : INT_MIN;
          ovf_next = !exact_min_reg;
        end else if ((mag[32:31] != 2'b00) && !(sign_reg && (mag == 33'h080000000))) begin
          q_next   = sign_reg ? INT_MIN : INT_MAX;
          ovf_next = 1'b1;
        end else begin
          q_next   = sign_reg ? (~mag[31:0] + 32'd1) : mag[31:0];
          ovf_next = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      f_reg         <= 32'd0;
      acc_reg       <= 32'd0;
      rem_reg       <= 5'd0;
      left_reg      <= 1'b0;
      sign_reg      <= 1'b0;
      sat_reg       <= 1'b0;
      nan_reg       <= 1'b0;
      exact_min_reg <= 1'b0;
      q_reg         <= 32'd0;
      ovf_reg       <= 1'b0;
      r_o_reg       <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef FP2INT_ROUND_NEAREST_EN
      guard_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      f_reg         <= f_next;
      acc_reg       <= acc_next;
      rem_reg       <= rem_next;
      left_reg      <= left_next;
      sign_reg      <= sign_next;
      sat_reg       <= sat_next;
      nan_reg       <= nan_next;
      exact_min_reg <= exact_min_next;
      q_reg         <= q_next;
      ovf_reg       <= ovf_next;
      r_o_reg       <= r_o_next;
      busy_reg      <= busy_next;
`ifdef FP2INT_ROUND_NEAREST_EN
      guard_reg     <= guard_next;
      sticky_reg    <= sticky_next;
`endif
    end
  end

  assign q    = q_reg;
  assign ovf  = ovf_reg;
  assign r_o  = r_o_reg;
  assign busy = busy_reg;

endmodule
